// File: rtl/d_mem_ctrl_pkg.sv
// ============================================================================
// d_mem_ctrl_pkg : shared memory-op type and LSQ/memory width macros
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 32
`endif

`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

package d_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        no_mem_op = 2'd0,
        mem_read  = 2'd1,
        mem_write = 2'd2
    } memory_op_t;

endpackage

`default_nettype wire

// File: rtl/d_mem_ctrl_if.sv
// ============================================================================
// d_mem_ctrl_if : LSQ <-> data-memory controller request/response bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface d_mem_ctrl_if;
    import d_mem_ctrl_pkg::*;

    logic                            lsq_req_valid;
    memory_op_t                      lsq_req_op;
    logic [`D_MEMORY_ADDR_WIDTH-1:0] lsq_req_address;
    logic [`REG_VAL_WIDTH-1:0]       lsq_req_data;
    logic                            mem_ctrl_ready;
    logic                            mem_ctrl_done;
    logic [`REG_VAL_WIDTH-1:0]       mem_ctrl_data;
    logic                            mem_ctrl_err;

    modport master (
        output lsq_req_valid, lsq_req_op, lsq_req_address, lsq_req_data,
        input  mem_ctrl_ready, mem_ctrl_done, mem_ctrl_data, mem_ctrl_err
    );

    modport slave (
        input  lsq_req_valid, lsq_req_op, lsq_req_address, lsq_req_data,
        output mem_ctrl_ready, mem_ctrl_done, mem_ctrl_data, mem_ctrl_err
    );

endinterface

`default_nettype wire

// File: rtl/d_mem_array.sv
// ============================================================================
// d_mem_array : single-port word array, synchronous write, combinational read
// Revision: 1.0
// ============================================================================
`default_nettype none

module d_mem_array #(
    parameter int MEM_DEPTH = 1024,
    parameter int IDXW      = $clog2(MEM_DEPTH),
    parameter int DW        = `REG_VAL_WIDTH
) (
    input  wire logic            clk,
    input  wire logic            wr_en,
    input  wire logic [IDXW-1:0] addr,
    input  wire logic [DW-1:0]   wr_data,
    output logic      [DW-1:0]   rd_data
);

    // Contents are intentionally left unreset.
    logic [DW-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    assign rd_data = mem[addr];

endmodule

`default_nettype wire

// File: rtl/d_mem_ctrl.sv
// ============================================================================
// d_mem_ctrl : data-memory controller, one LSQ transaction in flight with a
//              fixed access latency. Optional D_MEM_BOUNDS_CHECK_EN flags and
//              suppresses out-of-range accesses instead of wrapping them.
// Revision: 1.0
// ============================================================================
`default_nettype none

module d_mem_ctrl
    import d_mem_ctrl_pkg::*;
#(
    parameter int MEM_DEPTH      = 1024,
    parameter int ACCESS_LATENCY = 2
) (
    input wire logic   clk,
    input wire logic   reset,
    d_mem_ctrl_if.slave bus
);

    localparam int         IDXW     = $clog2(MEM_DEPTH);
    localparam int         AW       = `D_MEMORY_ADDR_WIDTH;
    localparam int         DW       = `REG_VAL_WIDTH;
    localparam logic [7:0] LAT_LOAD = 8'(ACCESS_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    memory_op_t    op_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [7:0]    lat_cnt;
    logic          done_q;
    logic          err_q;
    logic [DW-1:0] rdata_q;

    logic          accept;
    logic          access;
    logic          in_range;
    logic          wr_en;
    logic [DW-1:0] arr_rdata;

    assign accept = (state == IDLE) && bus.lsq_req_valid && (bus.lsq_req_op != no_mem_op);
    // The array is touched only on the final BUSY edge.
    assign access = (state == BUSY) && (lat_cnt == 8'd0);

`ifdef D_MEM_BOUNDS_CHECK_EN
    localparam logic [AW:0] DEPTH_EXT = (AW+1)'(MEM_DEPTH);
    assign in_range = ({1'b0, addr_q} < DEPTH_EXT);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[AW-1:IDXW];
    assign in_range       = 1'b1;
`endif

    assign wr_en = access && (op_q == mem_write) && in_range;

    d_mem_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDXW      (IDXW),
        .DW        (DW)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .addr    (addr_q[IDXW-1:0]),
        .wr_data (wdata_q),
        .rd_data (arr_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (lat_cnt == 8'd0) state_nxt = RESPOND;
            RESPOND: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q    <= no_mem_op;
            addr_q  <= '0;
            wdata_q <= '0;
            lat_cnt <= 8'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q <= access;
            err_q  <= access && !in_range;

            if (accept) begin
                op_q    <= bus.lsq_req_op;
                addr_q  <= bus.lsq_req_address;
                wdata_q <= bus.lsq_req_data;
                lat_cnt <= LAT_LOAD;
            end else if ((state == BUSY) && (lat_cnt != 8'd0)) begin
                lat_cnt <= lat_cnt - 8'd1;
            end

            // Read data persists across writes until the next read completes.
            if (access && (op_q == mem_read)) begin
                rdata_q <= in_range ? arr_rdata : '0;
            end
        end
    end

    assign bus.mem_ctrl_ready = (state == IDLE) && reset;
    assign bus.mem_ctrl_done  = done_q;
    assign bus.mem_ctrl_data  = rdata_q;
    assign bus.mem_ctrl_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_d_mem_ctrl.sv
// ============================================================================
// tb_d_mem_ctrl : scoreboard bench for d_mem_ctrl (honours D_MEM_BOUNDS_CHECK_EN)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_d_mem_ctrl;
    import d_mem_ctrl_pkg::*;

    localparam int MEM_DEPTH = 1024;
    localparam int LAT       = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    d_mem_ctrl_if bus();

    d_mem_ctrl #(
        .MEM_DEPTH      (MEM_DEPTH),
        .ACCESS_LATENCY (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] model [int];
    logic [31:0] last_rd = 32'h0;
    int          total   = 0;
    int          bad     = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, expv);
        end
    endtask

    // Reference behaviour of one accepted access.
    task automatic model_access(input memory_op_t op, input logic [31:0] addr,
                                input logic [31:0] d, output exp_t e);
        logic oor;
        int   idx;
`ifdef D_MEM_BOUNDS_CHECK_EN
        oor = (addr >= 32'(MEM_DEPTH));
`else
        oor = 1'b0;
`endif
        idx   = int'(addr & 32'(MEM_DEPTH - 1));
        e.err = oor;
        if (op == mem_write) begin
            if (!oor) model[idx] = d;
        end else begin
            last_rd = oor ? 32'h0 : (model.exists(idx) ? model[idx] : 32'hxxxx_xxxx);
        end
        e.data = last_rd;
    endtask

    always @(negedge clk) begin
        if (reset && bus.mem_ctrl_done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_data", bus.mem_ctrl_data, mon_e.data);
                check("resp_err", 32'(bus.mem_ctrl_err), 32'(mon_e.err));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (bus.mem_ctrl_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drive_idle();
        bus.lsq_req_valid   = 1'b0;
        bus.lsq_req_op      = no_mem_op;
        bus.lsq_req_address = 32'h0;
        bus.lsq_req_data    = 32'h0;
    endtask

    // Full transaction with cycle-exact timing checks; inject pulses a read of
    // addr 9 during the first BUSY cycle, which must be ignored.
    task automatic txn(input memory_op_t op, input logic [31:0] addr,
                       input logic [31:0] d, input bit inject);
        exp_t e;
        wait_ready();
        bus.lsq_req_valid   = 1'b1;
        bus.lsq_req_op      = op;
        bus.lsq_req_address = addr;
        bus.lsq_req_data    = d;
        model_access(op, addr, d, e);
        sb.push_back(e);
        @(negedge clk);
        drive_idle();
        for (int k = 1; k <= LAT; k++) begin
            check("busy_done", 32'(bus.mem_ctrl_done), 32'd0);
            check("busy_ready", 32'(bus.mem_ctrl_ready), 32'd0);
            if (inject && k == 1) begin
                bus.lsq_req_valid   = 1'b1;
                bus.lsq_req_op      = mem_read;
                bus.lsq_req_address = 32'd9;
            end
            @(negedge clk);
            drive_idle();
        end
        check("done_pulse", 32'(bus.mem_ctrl_done), 32'd1);
        check("resp_ready", 32'(bus.mem_ctrl_ready), 32'd0);
        @(negedge clk);
        check("ready_back", 32'(bus.mem_ctrl_ready), 32'd1);
        check("done_low", 32'(bus.mem_ctrl_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] v;
        drive_idle();
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.mem_ctrl_ready), 32'd0);
        check("rst_done", 32'(bus.mem_ctrl_done), 32'd0);
        check("rst_data", bus.mem_ctrl_data, 32'd0);
        check("rst_err", 32'(bus.mem_ctrl_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.mem_ctrl_ready), 32'd1);
        check("post_rst_data", bus.mem_ctrl_data, 32'd0);

        txn(mem_write, 32'd5, 32'hDEADBEEF, 1'b0);
        txn(mem_read,  32'd5, 32'h0, 1'b0);
        txn(mem_write, 32'd9, 32'h0909_0909, 1'b0);
        txn(mem_write, 32'd3, 32'h3333_3333, 1'b1);
        check("data_hold", bus.mem_ctrl_data, 32'hDEADBEEF);
        txn(mem_read,  32'd9, 32'h0, 1'b0);

        // no_mem_op strobe in IDLE
        bus.lsq_req_valid   = 1'b1;
        bus.lsq_req_op      = no_mem_op;
        bus.lsq_req_address = 32'd5;
        @(negedge clk);
        drive_idle();
        for (int k = 0; k < 4; k++) begin
            check("nop_ready", 32'(bus.mem_ctrl_ready), 32'd1);
            check("nop_done", 32'(bus.mem_ctrl_done), 32'd0);
            @(negedge clk);
        end

        // Reset asserted in cycle T+2 of a write aborts it
        txn(mem_write, 32'd7, 32'h0000_1111, 1'b0);
        wait_ready();
        bus.lsq_req_valid   = 1'b1;
        bus.lsq_req_op      = mem_write;
        bus.lsq_req_address = 32'd7;
        bus.lsq_req_data    = 32'h0000_1234;
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready", 32'(bus.mem_ctrl_ready), 32'd0);
        @(negedge clk);
        check("abort_done", 32'(bus.mem_ctrl_done), 32'd0);
        reset = 1'b1;
        last_rd = 32'h0;
        @(negedge clk);
        check("abort_done2", 32'(bus.mem_ctrl_done), 32'd0);
        check("abort_idle", 32'(bus.mem_ctrl_ready), 32'd1);
        check("abort_data", bus.mem_ctrl_data, 32'd0);
        txn(mem_read, 32'd7, 32'h0, 1'b0);

        // Address range boundaries
        txn(mem_write, 32'd0,    32'hA5A5_A5A5, 1'b0);
        txn(mem_write, 32'd1023, 32'h1023_1023, 1'b0);
        txn(mem_read,  32'd1023, 32'h0, 1'b0);
        txn(mem_read,  32'd1024, 32'h0, 1'b0);
        txn(mem_write, 32'd1024, 32'h0000_0077, 1'b0);
        txn(mem_read,  32'd0,    32'h0, 1'b0);
        txn(mem_read,  32'd5,    32'h0, 1'b0);

        // Back-to-back read-after-write on scattered addresses
        for (int i = 0; i < 8; i++) begin
            a = 32'($urandom_range(0, 63));
            v = 32'($urandom);
            txn(mem_write, a, v, 1'b0);
            txn(mem_read,  a, 32'h0, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
